// File: rtl/down_counter_4bit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : down_counter_4bit_pkg
// Brief    : Shared counter constants, all-ones helper and reload-mode enum.
// Revision : 1.0
// ============================================================================
package down_counter_4bit_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        WRAP   = 1'b0,
        RELOAD = 1'b1
    } reload_mode_e;

    // Callers narrow the 64-bit result to their own width.
    function automatic logic [63:0] ones(input int unsigned w);
        if (w >= 64)
            return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/down_counter_4bit_zero_detect.sv
`default_nettype none
// ============================================================================
// Module   : down_counter_4bit_zero_detect
// Brief    : WIDTH-input NOR; high when every input bit is zero.
// Revision : 1.0
// ============================================================================
module down_counter_4bit_zero_detect
    import down_counter_4bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_data,
    output logic             o_zero
);

    assign o_zero = ~|i_data;

endmodule
`default_nettype wire

// File: rtl/down_counter_4bit.sv
`default_nettype none
// ============================================================================
// Module   : down_counter_4bit
// Brief    : Loadable down-counter with borrow, wrap or auto-reload at zero.
// Revision : 1.0
// ============================================================================
module down_counter_4bit
    import down_counter_4bit_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] counter,
    output logic             bo,
    output logic             zero_hit
);

    localparam logic [WIDTH-1:0] C_ONES = WIDTH'(ones(WIDTH));
    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam reload_mode_e     C_MODE = AUTO_RELOAD ? RELOAD : WRAP;

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_rld;
    logic             r_zh;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_rld_nxt;
    logic             w_zh_nxt;
    logic             w_bo;

    down_counter_4bit_zero_detect #(
        .WIDTH (WIDTH)
    ) u_zero_detect (
        .i_data (r_cnt),
        .o_zero (w_bo)
    );

    // din only reaches state through the load branch, so an X on din is
    // harmless while load is low.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_rld_nxt = r_rld;
        w_zh_nxt  = 1'b0;
        if (load) begin
            w_cnt_nxt = din;
            w_rld_nxt = din;
        end else if (en) begin
            if (w_bo) begin
                w_cnt_nxt = (C_MODE == RELOAD) ? r_rld : C_ONES;
                w_zh_nxt  = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt - C_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_rld <= C_ONES;
            r_zh  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_rld <= w_rld_nxt;
            r_zh  <= w_zh_nxt;
        end
    end

    assign counter  = r_cnt;
    assign bo       = w_bo;
    assign zero_hit = r_zh;

endmodule
`default_nettype wire

// File: tb/tb_down_counter_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_down_counter_4bit
// Brief    : Directed vector bench for wrap, auto-reload and cascaded use.
// Revision : 1.0
// ============================================================================
module tb_down_counter_4bit;

    typedef struct {
        bit       sel;      // 0: wrap-mode instance, 1: auto-reload instance
        bit       rst;
        bit       load;
        bit       en;
        bit [3:0] din;
        bit [3:0] cnt;
        bit       bo;
        bit       zh;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // wrap-mode instance
    logic       w_rst, w_en, w_load, w_bo, w_zh;
    logic [3:0] w_din, w_cnt;
    // auto-reload instance
    logic       a_rst, a_en, a_load, a_bo, a_zh;
    logic [3:0] a_din, a_cnt;
    // two-stage cascade
    logic       c_rst, c_en, c_load, c0_bo, c0_zh, c1_bo, c1_zh;
    logic [3:0] c0_din, c1_din, c0_cnt, c1_cnt;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[$];

    down_counter_4bit #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut_wrap (
        .clk(clk), .rst(w_rst), .en(w_en), .load(w_load), .din(w_din),
        .counter(w_cnt), .bo(w_bo), .zero_hit(w_zh)
    );

    down_counter_4bit #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk(clk), .rst(a_rst), .en(a_en), .load(a_load), .din(a_din),
        .counter(a_cnt), .bo(a_bo), .zero_hit(a_zh)
    );

    down_counter_4bit #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut_c0 (
        .clk(clk), .rst(c_rst), .en(c_en), .load(c_load), .din(c0_din),
        .counter(c0_cnt), .bo(c0_bo), .zero_hit(c0_zh)
    );

    down_counter_4bit #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut_c1 (
        .clk(clk), .rst(c_rst), .en(c_en & c0_bo), .load(c_load), .din(c1_din),
        .counter(c1_cnt), .bo(c1_bo), .zero_hit(c1_zh)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit sel, bit rst, bit load, bit en, bit [3:0] din,
                                bit [3:0] cnt, bit bo, bit zh);
        vec_t v;
        v.sel = sel; v.rst = rst; v.load = load; v.en = en; v.din = din;
        v.cnt = cnt; v.bo = bo; v.zh = zh;
        return v;
    endfunction

    initial begin
        w_rst = 1'b0; w_en = 1'b0; w_load = 1'b0; w_din = '0;
        a_rst = 1'b0; a_en = 1'b0; a_load = 1'b0; a_din = '0;
        c_rst = 1'b0; c_en = 1'b0; c_load = 1'b0; c0_din = '0; c1_din = '0;

        //                sel rst ld en din cnt bo zh
        // wrap mode: reset, idle, load 3 and count through the wrap
        vecs.push_back(mk(0, 1, 0, 0,  0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0,  3,  3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0,  2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0, 15, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1,  0, 14, 0, 0));
        // load beats en; rst beats load and en
        vecs.push_back(mk(0, 0, 1, 0,  5,  5, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1,  9,  9, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  7,  7, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 12,  0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0, 15, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0,  6,  6, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0,  6, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1,  0,  0, 1, 0));
        // auto-reload: load 2 and run 7 cycles
        vecs.push_back(mk(1, 1, 0, 0,  0,  0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0,  2,  2, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1,  0,  1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1,  0,  0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1,  0,  2, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1,  0,  1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1,  0,  0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1,  0,  2, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1,  0,  1, 0, 0));
        // reset drops the reload value back to all-ones
        vecs.push_back(mk(1, 0, 1, 0,  7,  7, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 12,  0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1,  0, 15, 0, 1));
        // reload value of zero parks the count at zero
        vecs.push_back(mk(1, 0, 1, 0,  0,  0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1,  0,  0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1,  0,  0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0,  0,  0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            w_rst = 1'b0; w_load = 1'b0; w_en = 1'b0; w_din = 'x;
            a_rst = 1'b0; a_load = 1'b0; a_en = 1'b0; a_din = 'x;
            if (vecs[i].sel == 1'b0) begin
                w_rst = vecs[i].rst; w_load = vecs[i].load; w_en = vecs[i].en;
                if (vecs[i].load) w_din = vecs[i].din;
            end else begin
                a_rst = vecs[i].rst; a_load = vecs[i].load; a_en = vecs[i].en;
                if (vecs[i].load) a_din = vecs[i].din;
            end
            @(posedge clk);
            #1;
            if (vecs[i].sel == 1'b0) begin
                check($sformatf("vec%0d.counter", i), 32'(w_cnt), 32'(vecs[i].cnt));
                check($sformatf("vec%0d.bo", i),      32'(w_bo),  32'(vecs[i].bo));
                check($sformatf("vec%0d.zero_hit", i), 32'(w_zh), 32'(vecs[i].zh));
            end else begin
                check($sformatf("vec%0d.counter", i), 32'(a_cnt), 32'(vecs[i].cnt));
                check($sformatf("vec%0d.bo", i),      32'(a_bo),  32'(vecs[i].bo));
                check($sformatf("vec%0d.zero_hit", i), 32'(a_zh), 32'(vecs[i].zh));
            end
        end

        // two-stage cascade: combined value 0x10 counted down 17 times
        begin
            logic [7:0] model;
            logic       exp_zh1;
            @(negedge clk);
            c_rst = 1'b1;
            @(negedge clk);
            c_rst = 1'b0; c_load = 1'b1; c1_din = 4'h1; c0_din = 4'h0;
            @(posedge clk);
            #1;
            model = 8'h10;
            check("cascade.load", 32'({c1_cnt, c0_cnt}), 32'(model));
            for (int k = 0; k < 17; k++) begin
                @(negedge clk);
                c_load = 1'b0; c_en = 1'b1; c0_din = 'x; c1_din = 'x;
                @(posedge clk);
                #1;
                exp_zh1 = (model == 8'h00);
                model   = model - 8'h01;
                check($sformatf("cascade.step%0d", k), 32'({c1_cnt, c0_cnt}), 32'(model));
                check($sformatf("cascade.upper_zh%0d", k), 32'(c1_zh), 32'(exp_zh1));
            end
            check("cascade.final", 32'({c1_cnt, c0_cnt}), 32'hFF);
            @(negedge clk);
            c_en = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
